// File: rtl/iq_buf_reader.sv
// Playback reader for the 1-bit I/Q capture buffer: fetches 36-bit I/Q words
// from block RAM and emits one I/Q sample pair per accepted transfer, LSB first.
module iq_buf_reader #(
  parameter int WORD_W = 36,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] num_words,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [WORD_W-1:0] ram_do_i,
  input  logic [WORD_W-1:0] ram_do_q,
  output logic              s_valid,
  input  logic              s_ready,
  output logic              s_i,
  output logic              s_q,
  output logic              s_last,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W  = $clog2(WORD_W);
  localparam int PIPE_W = RD_LAT + 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FILL   = 2'd1;
  localparam logic [1:0] STREAM = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] last_addr;
  logic              loop_r;
  logic              fetch_end;
  logic              pend_last;
  logic [PIPE_W-1:0] rd_pipe;
  logic [WORD_W-1:0] hold_i, hold_q;
  logic              hold_full, hold_last;
  logic [WORD_W-1:0] sh_i, sh_q;
  logic              sh_full, sh_last;
  logic [BIT_W-1:0]  bit_cnt;

  logic go, zero_go, issue, capture, xfer, word_end, load_sh;

  // One fetch in flight at a time; rd_pipe tracks it until its data is valid.
  // NOTE: combinational logic uses blocking '=', registers below use '<='.
  always_comb begin
    go       = (state == IDLE) && start && !stop && (num_words != '0);
    zero_go  = (state == IDLE) && start && !stop && (num_words == '0);
    xfer     = sh_full && s_ready;
    word_end = xfer && (bit_cnt == LAST_BIT);
    load_sh  = hold_full && (!sh_full || word_end);
    issue    = ((state == FILL) || (state == STREAM)) && (!hold_full || load_sh) &&
               (rd_pipe == '0) && !fetch_end;
    capture  = rd_pipe[RD_LAT];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ram_addr  <= '0;
      last_addr <= '0;
      loop_r    <= 1'b0;
      fetch_end <= 1'b0;
      pend_last <= 1'b0;
      rd_pipe   <= '0;
      hold_i    <= '0;
      hold_q    <= '0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      sh_i      <= '0;
      sh_q      <= '0;
      sh_full   <= 1'b0;
      sh_last   <= 1'b0;
      bit_cnt   <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state != IDLE) && stop) begin
        state     <= IDLE;
        ram_addr  <= '0;
        fetch_end <= 1'b0;
        rd_pipe   <= '0;
        hold_full <= 1'b0;
        sh_full   <= 1'b0;
      end else begin
        rd_pipe <= (rd_pipe << 1) | PIPE_W'(go || issue);

        // Address moves on the cycle after a fetch is launched, once the RAM has taken it.
        if (go) begin
          ram_addr  <= '0;
          last_addr <= num_words - 1'b1;
          loop_r    <= loop_en;
          fetch_end <= 1'b0;
          pend_last <= (num_words == ADDR_W'(1));
          state     <= FILL;
        end else if (rd_pipe[0]) begin
          if (ram_addr == last_addr) begin
            if (loop_r) ram_addr <= '0;
            else        fetch_end <= 1'b1;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end
        if (issue) pend_last <= (ram_addr == last_addr);

        if (capture) begin
          hold_i    <= ram_do_i;
          hold_q    <= ram_do_q;
          hold_last <= pend_last;
          hold_full <= 1'b1;
        end else if (load_sh) begin
          hold_full <= 1'b0;
        end

        if (load_sh) begin
          sh_i    <= hold_i;
          sh_q    <= hold_q;
          sh_last <= hold_last;
          bit_cnt <= '0;
          sh_full <= 1'b1;
        end else if (word_end) begin
          sh_full <= 1'b0;
        end else if (xfer) begin
          sh_i    <= sh_i >> 1;
          sh_q    <= sh_q >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end

        case (state)
          IDLE:         if (zero_go) done <= 1'b1;
          FILL, STREAM: if (load_sh) state <= (hold_last && !loop_r) ? DRAIN : STREAM;
          DRAIN: begin
            if (word_end) begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
          default:      state <= IDLE;
        endcase
      end
    end
  end

  assign s_valid = sh_full;
  assign s_i     = sh_i[0];
  assign s_q     = sh_q[0];
  assign s_last  = sh_full && sh_last && (bit_cnt == LAST_BIT);
  assign busy    = (state != IDLE);

endmodule

// File: doc/iq_buf_reader.md
# iq_buf_reader

Playback side of the 1-bit I/Q capture buffer. After capture has filled the two 36-bit block RAMs (I and Q), this block reads them back word by word and serialises the contents into one I/Q sample pair per accepted transfer. Samples leave in capture order, so they can feed the acquisition correlator. It drives the shared RAM address port and presents a valid/ready sample stream downstream, with optional wrap-around for repeated passes over the buffer.

## Interface
- `WORD_W`, 36: bits per RAM word, equal to samples per word.
- `ADDR_W`, 9: RAM address width.
- `RD_LAT`, 2: clocks from `ram_addr` change to valid `ram_do_i`/`ram_do_q`; legal range 1..3.

- `clk` in 1: system clock. One clock domain only.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin a pass. Sampled only in IDLE.
- `stop` in 1: synchronous abort.
- `loop_en` in 1: after the last word, wrap to address 0 and continue. Sampled at `start`.
- `num_words` in ADDR_W: words per pass, 1..511. 0 = no-op. Sampled at `start`.
- `ram_addr` out ADDR_W: RAM word address. The read strobe is implied: the RAM reads every cycle.
- `ram_do_i`, `ram_do_q` in WORD_W: RAM read data.
- `s_valid` out 1: a sample pair is presented.
- `s_ready` in 1: downstream accepts the sample.
- `s_i`, `s_q` out 1: sample bits.
- `s_last` out 1: marks the final sample of a pass. Qualified by `s_valid`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a non-looping pass.

## Operation
- **Word/bit mapping.**
  - Sample k of word a is bit k of the RAM data, bit 0 first. This matches capture, which writes bit `buf_count` starting at 0.
  - Word 0 is emitted first. The I and Q words share an address.
- **States:** IDLE, FILL, STREAM, DRAIN.
  - IDLE → FILL: on `start` with `num_words` ≠ 0. Latch `num_words` and `loop_en`; set `ram_addr`=0.
  - IDLE, with `start` and `num_words`=0: `done` pulses the next cycle and the state stays IDLE.
  - FILL: wait RD_LAT cycles, load word 0 into the I/Q shift registers, go to STREAM.
  - STREAM:
    - Each accepted transfer (`s_valid`&`s_ready`) shifts both registers right by one.
    - The next word is prefetched into a one-word holding register, so streaming is gapless when `s_ready` is held high.
    - The address increments once per word fetched. After `num_words`−1 it wraps to 0 if `loop_en` is set; otherwise no further fetch is made.
  - DRAIN: entered once the final word of a non-looping pass is in the shift register. After the last sample is accepted, pulse `done` and return to IDLE.
- **`s_last`:** set on bit WORD_W−1 of word `num_words`−1. With `loop_en` set, it is asserted on every pass.
- **Backpressure:** while `s_valid` is high and `s_ready` is low, `s_i`, `s_q` and `s_last` hold stable and no shift occurs.
- **Abort:** `stop` in any non-IDLE state returns to IDLE on the next edge. `s_valid` drops and no `done` is issued. `stop` has priority over `start`.
- **Busy:** `start` is ignored while `busy`.
- **Reset values:** IDLE; `ram_addr`=0, `s_valid`=0, `s_i`=`s_q`=0, `s_last`=0, `busy`=0, `done`=0. Holding registers are cleared.
- **Reset mid-pass:** outputs return to reset values immediately (asynchronous). There is no resume.

## Timing
- The first `s_valid` occurs RD_LAT+2 cycles after the edge that samples `start`. This is 4 cycles at the default.
- `busy` rises one cycle after `start` and falls in the same cycle `done` pulses.
- Per-word cost is exactly WORD_W accepted transfers. There are no bubbles across word or wrap boundaries while `s_ready`=1.
- Holding-register refill completes within RD_LAT+1 cycles of the register emptying. WORD_W > RD_LAT+1 guarantees it is never late.
- `done` pulses one cycle after the final accepted transfer.

## Test plan
- **Basic pass:** RAM preloaded with I word a = a·0x1_0000_0001 + 0x5, Q word = ~I; `num_words`=3, `s_ready`=1.
  - Expect 108 samples matching the RAM bits, LSB first.
  - `s_last` appears only on sample 107.
  - `done` pulses 1 cycle later and no `s_valid` gaps occur.
- **Random backpressure:** `s_ready` toggled pseudo-randomly (50%), `num_words`=112.
  - Expect 4032 samples identical to the basic-pass order, with outputs held stable when stalled.
- **Looping:** `loop_en`=1, `num_words`=2, run 200 transfers.
  - Samples repeat with period 72 and `s_last` appears at 71, 143.
  - `stop` at transfer 150 gives IDLE next cycle, with no `done`.
- **Edge lengths:**
  - `num_words`=0 gives `done` 1 cycle after `start` with `busy` never high.
  - `num_words`=1 gives exactly 36 samples.
- **Ignored start and reset:** a `start` during STREAM is ignored.
  - Asserting `rst` low mid-word clears all outputs immediately.
  - A fresh `start` after reset restarts from word 0.
- **Latency:** with RD_LAT=1 and RD_LAT=3, first `s_valid` occurs at 3 and 5 cycles respectively, and the data is correct.
